// File: rtl/load_rs_param.sv
// Load reservation station for the Tomasulo core.
// Holds up to DEPTH pending loads. Each entry waits for its base operand,
// either supplied at dispatch or captured from one of two CDB ports.
// The oldest ready entry moves into a single output register, which presents
// base + offset to the load unit over a valid/ready handshake.
module load_rs_param #(
    parameter int                DEPTH       = 4,
    parameter int                XLEN        = 32,
    parameter int                TAG_W       = 6,
    parameter logic [TAG_W-1:0]  INVALID_TAG = 6'b010000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [2:0]                   alloc_sub_type,
    input  logic [XLEN-1:0]              alloc_base,
    input  logic [TAG_W-1:0]             alloc_base_tag,
    input  logic [XLEN-1:0]              alloc_offset,
    input  logic [TAG_W-1:0]             alloc_rob,
    input  logic                         cdb0_valid,
    input  logic [TAG_W-1:0]             cdb0_tag,
    input  logic [XLEN-1:0]              cdb0_data,
    input  logic                         cdb1_valid,
    input  logic [TAG_W-1:0]             cdb1_tag,
    input  logic [XLEN-1:0]              cdb1_data,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [XLEN-1:0]              issue_addr,
    output logic [2:0]                   issue_type,
    output logic [TAG_W-1:0]             issue_rob,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                CNT_W     = $clog2(DEPTH + 1);
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [DEPTH-1:0]  ONE_VEC   = DEPTH'(1'b1);
    localparam logic [IDX_W-1:0]  ONE_AGE   = IDX_W'(1'b1);

    // A CDB port delivers the operand for 'tag' when it is valid and names
    // that tag; the ready marker itself can never be woken.
    function automatic logic cdb_hit(
        input logic             cdb_valid,
        input logic [TAG_W-1:0] cdb_tag,
        input logic [TAG_W-1:0] tag
    );
        cdb_hit = cdb_valid && (cdb_tag == tag) && (tag != INVALID_TAG);
    endfunction

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]   ent_valid_r;
    logic [2:0]         ent_type_r [DEPTH];
    logic [XLEN-1:0]    ent_base_r [DEPTH];
    logic [TAG_W-1:0]   ent_tag_r  [DEPTH];
    logic [XLEN-1:0]    ent_off_r  [DEPTH];
    logic [TAG_W-1:0]   ent_rob_r  [DEPTH];
    logic [IDX_W-1:0]   ent_age_r  [DEPTH];

    logic [DEPTH-1:0]   ent_valid_nx_s;
    logic [2:0]         ent_type_nx_s [DEPTH];
    logic [XLEN-1:0]    ent_base_nx_s [DEPTH];
    logic [TAG_W-1:0]   ent_tag_nx_s  [DEPTH];
    logic [XLEN-1:0]    ent_off_nx_s  [DEPTH];
    logic [TAG_W-1:0]   ent_rob_nx_s  [DEPTH];
    logic [IDX_W-1:0]   ent_age_nx_s  [DEPTH];

    // Output register and occupancy
    logic [CNT_W-1:0]   count_r;
    logic               alloc_ready_r;
    logic               issue_valid_r;
    logic [XLEN-1:0]    issue_addr_r;
    logic [2:0]         issue_type_r;
    logic [TAG_W-1:0]   issue_rob_r;

    logic [CNT_W-1:0]   count_nx_s;
    logic               alloc_ready_nx_s;
    logic               issue_valid_nx_s;
    logic [XLEN-1:0]    issue_addr_nx_s;
    logic [2:0]         issue_type_nx_s;
    logic [TAG_W-1:0]   issue_rob_nx_s;

    // Per-entry status
    logic [DEPTH-1:0]   ready_s;
    logic [DEPTH-1:0]   wake0_s;
    logic [DEPTH-1:0]   wake1_s;
    logic [DEPTH-1:0]   sel_onehot_s;
    logic [DEPTH-1:0]   free_vec_s;
    logic [DEPTH-1:0]   free_onehot_s;

    // Selected candidate fields
    logic               cand_found_s;
    logic [IDX_W-1:0]   cand_age_s;
    logic [XLEN-1:0]    cand_base_s;
    logic [XLEN-1:0]    cand_off_s;
    logic [2:0]         cand_type_s;
    logic [TAG_W-1:0]   cand_rob_s;

    // Handshake and allocation control
    logic               issue_take_s;
    logic               alloc_fire_s;
    logic               alloc_wake0_s;
    logic               alloc_wake1_s;
    logic [IDX_W-1:0]   alloc_age_s;
    logic [XLEN-1:0]    alloc_base_s;
    logic [TAG_W-1:0]   alloc_tag_s;

    assign alloc_ready = alloc_ready_r;
    assign issue_valid = issue_valid_r;
    assign issue_addr  = issue_addr_r;
    assign issue_type  = issue_type_r;
    assign issue_rob   = issue_rob_r;
    assign count       = count_r;

    // Per-entry readiness (registered tag only) and CDB wakeup detection.
    always_comb begin
        ready_s = '0;
        wake0_s = '0;
        wake1_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = ent_valid_r[i] && (ent_tag_r[i] == INVALID_TAG);
            wake0_s[i] = ent_valid_r[i] && cdb_hit(cdb0_valid, cdb0_tag, ent_tag_r[i]);
            wake1_s[i] = ent_valid_r[i] && cdb_hit(cdb1_valid, cdb1_tag, ent_tag_r[i]);
        end
    end

    // Oldest-ready selection: an entry wins when no other ready entry is
    // older. Ages are unique among valid entries, so the result is one-hot.
    always_comb begin
        sel_onehot_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_onehot_s[i] = ready_s[i];
            for (int j = 0; j < DEPTH; j++) begin
                sel_onehot_s[i] = sel_onehot_s[i]
                                & ~(ready_s[j] & (ent_age_r[j] < ent_age_r[i]));
            end
        end
        cand_found_s = |sel_onehot_s;
        cand_age_s   = '0;
        cand_base_s  = '0;
        cand_off_s   = '0;
        cand_type_s  = '0;
        cand_rob_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cand_age_s  = cand_age_s  | (sel_onehot_s[i] ? ent_age_r[i]  : '0);
            cand_base_s = cand_base_s | (sel_onehot_s[i] ? ent_base_r[i] : '0);
            cand_off_s  = cand_off_s  | (sel_onehot_s[i] ? ent_off_r[i]  : '0);
            cand_type_s = cand_type_s | (sel_onehot_s[i] ? ent_type_r[i] : '0);
            cand_rob_s  = cand_rob_s  | (sel_onehot_s[i] ? ent_rob_r[i]  : '0);
        end
    end

    // Handshake, free-slot search, allocation bypass and occupancy update.
    always_comb begin
        issue_take_s  = cand_found_s && (!issue_valid_r || issue_ready);
        alloc_fire_s  = alloc_valid && alloc_ready_r;
        // Only slots free in the registered state are usable, so a slot
        // vacated by this cycle's issue waits one cycle before reuse.
        free_vec_s    = ~ent_valid_r;
        free_onehot_s = free_vec_s & (~free_vec_s + ONE_VEC);
        // Newest entry sits behind everything that survives this edge.
        alloc_age_s   = IDX_W'(count_r - CNT_W'(issue_take_s));
        alloc_wake0_s = cdb_hit(cdb0_valid, cdb0_tag, alloc_base_tag);
        alloc_wake1_s = cdb_hit(cdb1_valid, cdb1_tag, alloc_base_tag);
        alloc_base_s  = alloc_wake0_s ? cdb0_data
                      : (alloc_wake1_s ? cdb1_data : alloc_base);
        alloc_tag_s   = (alloc_wake0_s || alloc_wake1_s) ? INVALID_TAG : alloc_base_tag;
        count_nx_s    = count_r + CNT_W'(alloc_fire_s) - CNT_W'(issue_take_s);
        alloc_ready_nx_s = (count_nx_s < DEPTH_CNT);
    end

    // Next state of every entry: allocation write, or wakeup / removal /
    // age compaction of an existing entry.
    always_comb begin
        ent_valid_nx_s = ent_valid_r;
        for (int i = 0; i < DEPTH; i++) begin
            ent_type_nx_s[i] = ent_type_r[i];
            ent_base_nx_s[i] = ent_base_r[i];
            ent_tag_nx_s[i]  = ent_tag_r[i];
            ent_off_nx_s[i]  = ent_off_r[i];
            ent_rob_nx_s[i]  = ent_rob_r[i];
            ent_age_nx_s[i]  = ent_age_r[i];
            if (alloc_fire_s && free_onehot_s[i]) begin
                ent_valid_nx_s[i] = 1'b1;
                ent_type_nx_s[i]  = alloc_sub_type;
                ent_base_nx_s[i]  = alloc_base_s;
                ent_tag_nx_s[i]   = alloc_tag_s;
                ent_off_nx_s[i]   = alloc_offset;
                ent_rob_nx_s[i]   = alloc_rob;
                ent_age_nx_s[i]   = alloc_age_s;
            end else begin
                ent_valid_nx_s[i] = ent_valid_r[i] & ~(issue_take_s & sel_onehot_s[i]);
                ent_age_nx_s[i]   = (issue_take_s && ent_valid_r[i] && (ent_age_r[i] > cand_age_s))
                                  ? (ent_age_r[i] - ONE_AGE) : ent_age_r[i];
                ent_base_nx_s[i]  = wake0_s[i] ? cdb0_data
                                  : (wake1_s[i] ? cdb1_data : ent_base_r[i]);
                ent_tag_nx_s[i]   = (wake0_s[i] || wake1_s[i]) ? INVALID_TAG : ent_tag_r[i];
            end
        end
    end

    // Output register: load on a free/accepted slot, hold under
    // back-pressure, drain when accepted with nothing to replace it.
    always_comb begin
        issue_valid_nx_s = issue_take_s || (issue_valid_r && !issue_ready);
        issue_addr_nx_s  = issue_take_s ? (cand_base_s + cand_off_s) : issue_addr_r;
        issue_type_nx_s  = issue_take_s ? cand_type_s : issue_type_r;
        issue_rob_nx_s   = issue_take_s ? cand_rob_s  : issue_rob_r;
    end

    // State registers: reset, then flush, then normal update.
    always_ff @(posedge clock) begin
        if (reset) begin
            ent_valid_r   <= '0;
            count_r       <= '0;
            alloc_ready_r <= 1'b1;
            issue_valid_r <= 1'b0;
            issue_addr_r  <= '0;
            issue_type_r  <= '0;
            issue_rob_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_type_r[i] <= '0;
                ent_base_r[i] <= '0;
                ent_tag_r[i]  <= INVALID_TAG;
                ent_off_r[i]  <= '0;
                ent_rob_r[i]  <= '0;
                ent_age_r[i]  <= '0;
            end
        end else if (flush) begin
            ent_valid_r   <= '0;
            count_r       <= '0;
            alloc_ready_r <= 1'b1;
            issue_valid_r <= 1'b0;
        end else begin
            ent_valid_r   <= ent_valid_nx_s;
            count_r       <= count_nx_s;
            alloc_ready_r <= alloc_ready_nx_s;
            issue_valid_r <= issue_valid_nx_s;
            issue_addr_r  <= issue_addr_nx_s;
            issue_type_r  <= issue_type_nx_s;
            issue_rob_r   <= issue_rob_nx_s;
            for (int i = 0; i < DEPTH; i++) begin
                ent_type_r[i] <= ent_type_nx_s[i];
                ent_base_r[i] <= ent_base_nx_s[i];
                ent_tag_r[i]  <= ent_tag_nx_s[i];
                ent_off_r[i]  <= ent_off_nx_s[i];
                ent_rob_r[i]  <= ent_rob_nx_s[i];
                ent_age_r[i]  <= ent_age_nx_s[i];
            end
        end
    end

endmodule

// File: doc/load_rs_param.md
Name: load_rs_param

Overview:
- Parametrised load reservation station for the Tomasulo core. It holds up to DEPTH pending loads.
- Each entry captures its base-register operand either at dispatch or by snooping two CDB ports. It computes the effective address as base + offset.
- It issues the oldest ready load to the load unit over a valid/ready handshake.
- Adds several features: synchronous reset, pipeline flush, oldest-first selection, same-cycle CDB bypass at allocation, and a back-pressured output.

Parameters:
- DEPTH, 4, number of entries (2..16).
- XLEN, 32, data/address width.
- TAG_W, 6, ROB tag width.
- INVALID_TAG, 6'b010000, tag value meaning "operand ready" (never a live ROB tag).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous squash of all entries and the output register.
- alloc_valid  in  1  dispatch presents a load.
- alloc_ready  out  1  station can accept (count < DEPTH).
- alloc_sub_type  in  3  funct3 (LB=000, LH=001, LW=010, LBU=100, LHU=101).
- alloc_base  in  XLEN  base value, meaningful when alloc_base_tag == INVALID_TAG.
- alloc_base_tag  in  TAG_W  producer ROB tag or INVALID_TAG.
- alloc_offset  in  XLEN  sign-extended immediate.
- alloc_rob  in  TAG_W  destination ROB tag.
- cdb0_valid, cdb1_valid  in  1  broadcast strobes.
- cdb0_tag, cdb1_tag  in  TAG_W  broadcasting ROB tag.
- cdb0_data, cdb1_data  in  XLEN  broadcast value.
- issue_valid  out  1  output register holds a load.
- issue_ready  in  1  load unit accepts.
- issue_addr  out  XLEN  base + offset, modulo 2^XLEN.
- issue_type  out  3  sub-type.
- issue_rob  out  TAG_W  destination ROB tag.
- count  out  $clog2(DEPTH+1)  occupied entries, excluding the output register.

Behaviour:
- Reset: all entries invalid, count=0, issue_valid=0, issue_addr/type/rob=0, alloc_ready=1. Reset has priority over flush, and flush has priority over every other update.
- Flush: at the edge, all entries and issue_valid clear. A same-cycle alloc is dropped. Any pending issue handshake is considered not taken.
- Entry state: valid, sub_type, base, tag, offset, rob, age.
- Allocation: an entry is written when alloc_valid && alloc_ready, into the lowest-index free entry.
  - alloc_ready derives from registered count only. A slot freed in the same cycle is not reusable until the next cycle.
- Allocation bypass: if alloc_base_tag != INVALID_TAG and it equals the tag on a valid CDB port in the same cycle, the entry stores that CDB data with tag=INVALID_TAG.
  - cdb0 wins if both CDB ports match.
- Wakeup: every valid entry with tag==cdbX_tag (X valid, tag != INVALID_TAG) captures data and sets tag=INVALID_TAG at the edge. Both ports are evaluated in parallel, with cdb0 winning on a duplicate tag.
- Age: a new entry's age = number of valid entries remaining after this cycle's issue removal. When an entry leaves, every entry with a larger age decrements. Ages among valid entries are always a permutation of 0..count-1.
- Selection: among entries whose registered tag==INVALID_TAG, choose minimum age. Wakeup is not bypassed into selection, so an operand woken at edge N is selectable for edge N+1.
- Output register load: loads when (!issue_valid || issue_ready) and a candidate exists.
  - Writes issue_addr = base+offset (carry discarded), issue_type, issue_rob, issue_valid=1.
  - Frees the entry and decrements count, all at the same edge.
- Output register hold: if issue_valid && !issue_ready, outputs hold stable and no entry is freed.
- Output register drain: issue_valid clears on accept when no candidate exists.
- Minimum latency: a load allocated ready at edge N is issue_valid after edge N+1.
- Simultaneous alloc + issue in one cycle: the count change is net (+1-1=0).
- Full: alloc_ready=0; alloc_valid is ignored with no state change.
- Empty: issue_valid drops after the last accept.

Test Plan:
- Ready-operand load: alloc base=0x1000, tag=INVALID, offset=0xFFFFFFFC, rob=5, type=010, issue_ready=1 -> issue_valid one cycle after alloc edge, addr=0x00000FFC, rob=5, count back to 0.
- Wakeup ordering: alloc A (rob=1, tag=3), then B (rob=2, tag=4). CDB1 broadcasts tag=4 data=0x20; next cycle CDB0 broadcasts tag=3 data=0x10 -> B issues first (only ready). Then A issues with addr=0x10+offset.
- Oldest-first: fill DEPTH=4 with ready loads rob=7,8,9,10, issue_ready=1 -> issue_rob sequence 7,8,9,10. alloc_ready=0 while count=4; an alloc attempted while full is dropped.
- Back-pressure plus same-cycle bypass: issue_ready=0 for 5 cycles -> issue_addr/rob stable, count unchanged. Alloc with base_tag=12 while cdb0 broadcasts tag=12 data=0x40 -> entry ready, issues with addr=0x40+offset.
- Flush: 3 entries plus a valid output; assert flush with alloc_valid=1 -> next cycle count=0, issue_valid=0, alloc dropped.
- Reset: reset mid-operation -> all outputs at reset values, alloc_ready=1.
